lin_comb_n: RTL and testbench

- N-channel weighted combiner: out = sat(Σk scale_k × in_k) over NUM_CH complex IQ channels, each weighted by a signed real scale.
- Successor to the 2-input scale-and-add stage. Adds parametrised channel count, full AXI-stream backpressure with no beat loss, optional per-packet scale latching, and a sticky saturation flag.
- Sits in the per-sample datapath between channel alignment and the downstream FIFO/packetiser.

---
 rtl/lin_comb_n_if.sv | 36 +++
 rtl/lin_comb_n.sv | 149 ++++++++++++++
 tb/tb_lin_comb_n.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lin_comb_n_if.sv
// Stream bundle for lin_comb_n.
//   master (upstream/downstream side): drives in_tvalid/in_tlast/in_tdata,
//     scale_tdata, scale_latch, sat_clear, out_tready.
//   slave (the combiner): drives in_tready, out_tvalid/out_tlast/out_tdata,
//     sat_flag.
// in_tdata: channel k at [k*2W +: 2W], I upper W bits, Q lower W bits.
// scale_tdata: signed scale for channel k at [k*W +: W].
interface lin_comb_n_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
);
  logic                             in_tvalid;
  logic                             in_tlast;
  logic                             in_tready;
  logic [NUM_CH*2*DATA_WIDTH-1:0]   in_tdata;
  logic [NUM_CH*DATA_WIDTH-1:0]     scale_tdata;
  logic                             scale_latch;
  logic                             sat_clear;
  logic                             sat_flag;
  logic                             out_tvalid;
  logic                             out_tlast;
  logic                             out_tready;
  logic [2*DATA_WIDTH-1:0]          out_tdata;

  modport master (
    output in_tvalid, in_tlast, in_tdata, scale_tdata, scale_latch,
           sat_clear, out_tready,
    input  in_tready, out_tvalid, out_tlast, out_tdata, sat_flag
  );

  modport slave (
    input  in_tvalid, in_tlast, in_tdata, scale_tdata, scale_latch,
           sat_clear, out_tready,
    output in_tready, out_tvalid, out_tlast, out_tdata, sat_flag
  );
endinterface

// File: rtl/lin_comb_n.sv
// N-channel weighted IQ combiner: out = sat(sum_k scale_k * in_k).
// Two register stages (S1: clipped per-channel products, S2: adder tree and
// final clip), AXI-stream backpressure, optional per-packet scale latching,
// sticky saturation flag.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - lin_comb_n_if slave modport (input/output streams, scale
//              mode, saturation flag and clear)
module lin_comb_n #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int DROP_TOP_P = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  lin_comb_n_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int N  = NUM_CH;
  localparam int SH = W - DROP_TOP_P;
  localparam int SW = W + $clog2(N);

  // Product scaled down by 2^SH (floor), clipped to W bits; MSB = clip event.
  function automatic logic [W:0] mul_clip(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    logic signed [2*W-1:0] r;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    r = p >>> SH;
    if (r[2*W-1:W-1] == '0 || r[2*W-1:W-1] == '1)
      return {1'b0, r[W-1:0]};
    else if (r[2*W-1])
      return {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  // Sum of N clipped products (width SW never overflows), clipped to W bits.
  function automatic logic [W:0] sum_clip(input logic [SW-1:0] s);
    if (s[SW-1:W-1] == '0 || s[SW-1:W-1] == '1)
      return {1'b0, s[W-1:0]};
    else if (s[SW-1])
      return {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  logic                r_v1, r_v2, r_last1, r_last2, r_first, r_sat_flag;
  logic signed [W-1:0] r_held [N];
  logic signed [W-1:0] r_pi   [N];
  logic signed [W-1:0] r_pq   [N];
  logic [2*W-1:0]      r_out;

  logic                w_adv1, w_adv2, w_acc, w_use_held, w_psat, w_ssat;
  logic signed [W-1:0] w_sc [N];
  logic signed [W-1:0] w_pi [N];
  logic signed [W-1:0] w_pq [N];
  logic [N-1:0]        w_sat_i, w_sat_q;
  logic [SW-1:0]       w_acc_i, w_acc_q;
  logic [W-1:0]        w_si, w_sq;
  logic                w_ssat_i, w_ssat_q;

  assign w_adv2     = !r_v2 || bus.out_tready;
  assign w_adv1     = !r_v1 || w_adv2;
  assign w_acc      = bus.in_tvalid && w_adv1;
  // Held scales apply only to non-first beats of a packet in latch mode.
  assign w_use_held = bus.scale_latch && !r_first;

  always_comb begin
    w_sat_i = '0;
    w_sat_q = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sc[k] = w_use_held ? r_held[k] : bus.scale_tdata[k*W +: W];
      {w_sat_i[k], w_pi[k]} = mul_clip(w_sc[k], bus.in_tdata[k*2*W+W +: W]);
      {w_sat_q[k], w_pq[k]} = mul_clip(w_sc[k], bus.in_tdata[k*2*W +: W]);
    end
    w_psat = |{w_sat_i, w_sat_q};
  end

  always_comb begin
    w_acc_i = '0;
    w_acc_q = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_acc_i = w_acc_i + {{(SW-W){r_pi[k][W-1]}}, r_pi[k]};
      w_acc_q = w_acc_q + {{(SW-W){r_pq[k][W-1]}}, r_pq[k]};
    end
    {w_ssat_i, w_si} = sum_clip(w_acc_i);
    {w_ssat_q, w_sq} = sum_clip(w_acc_q);
    w_ssat = w_ssat_i || w_ssat_q;
  end

  // S1 plus scale-latch bookkeeping. Outside latch mode the held scales
  // follow every accepted beat, so enabling latch mid-packet reuses the
  // most recent scales.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_first <= 1'b1;
      for (int unsigned k = 0; k < N; k++) begin
        r_held[k] <= '0;
        r_pi[k]   <= '0;
        r_pq[k]   <= '0;
      end
    end else begin
      if (w_adv1) r_v1 <= bus.in_tvalid;
      if (w_acc) begin
        r_last1 <= bus.in_tlast;
        r_first <= bus.in_tlast;
        for (int unsigned k = 0; k < N; k++) begin
          r_pi[k] <= w_pi[k];
          r_pq[k] <= w_pq[k];
          if (!w_use_held) r_held[k] <= w_sc[k];
        end
      end
    end
  end

  // S2: output register, held while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_out   <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out   <= {w_si, w_sq};
        r_last2 <= r_last1;
      end
    end
  end

  // Sticky saturation flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_sat_flag <= 1'b0;
    else
      r_sat_flag <= (w_acc && w_psat) || (w_adv2 && r_v1 && w_ssat) ||
                    (r_sat_flag && !bus.sat_clear);
  end

  assign bus.in_tready  = w_adv1;
  assign bus.out_tvalid = r_v2;
  assign bus.out_tlast  = r_last2;
  assign bus.out_tdata  = r_out;
  assign bus.sat_flag   = r_sat_flag;
endmodule

// File: tb/tb_lin_comb_n.sv
// Self-checking bench for lin_comb_n: directed literal cases plus a random
// backpressured stream compared against an arithmetic reference model.
module tb_lin_comb_n;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int D  = 6;
  localparam int SH = W - D;
  localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W-1));

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lin_comb_n_if #(.DATA_WIDTH(W), .NUM_CH(N)) bus();

  lin_comb_n #(.DATA_WIDTH(W), .NUM_CH(N), .DROP_TOP_P(D)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint fdiv(input longint p);
    longint d;
    longint q;
    d = longint'(1) <<< SH;
    q = p / d;
    if ((p % d) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clipv(input longint v, output bit s);
    s = 1'b0;
    if (v > MAXV) begin s = 1'b1; return MAXV; end
    if (v < MINV) begin s = 1'b1; return MINV; end
    return v;
  endfunction

  function automatic void model_beat(input logic [N*2*W-1:0] d,
                                     input logic [N*W-1:0] s,
                                     output logic [2*W-1:0] o,
                                     output bit sat);
    longint si, sq, sc, xi, xq;
    bit e;
    si = 0; sq = 0; sat = 1'b0;
    for (int k = 0; k < N; k++) begin
      sc = longint'($signed(s[k*W +: W]));
      xi = longint'($signed(d[k*2*W+W +: W]));
      xq = longint'($signed(d[k*2*W +: W]));
      si += clipv(fdiv(sc * xi), e); sat |= e;
      sq += clipv(fdiv(sc * xq), e); sat |= e;
    end
    si = clipv(si, e); sat |= e;
    sq = clipv(sq, e); sat |= e;
    o = {si[W-1:0], sq[W-1:0]};
  endfunction

  typedef struct {
    logic [2*W-1:0] data;
    logic           last;
    bit             sat;
    int             cyc;
  } beat_t;

  beat_t          q[$];
  beat_t          e_pop, e_new;
  bit             first = 1'b1;
  bit             any_sat = 1'b0;
  bit             lat_chk = 1'b0;
  logic [N*W-1:0] held = '0;
  logic [N*W-1:0] use_s;
  logic [2*W-1:0] prev_data;
  logic           prev_last;
  bit             prev_stall = 1'b0;
  int             cyc = 0;
  int             occ;
  int             n_out = 0;
  int             last_i, last_q;
  int             out_i_log[$];
  int             rdy_mode = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.out_tready = 1'b1;
      1: bus.out_tready = 1'($urandom_range(0, 1));
      default: bus.out_tready = 1'b0;
    endcase
  end

  // Compare process: all sampling mid-cycle; handshakes complete at the
  // following rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      first = 1'b1;
      held = '0;
      any_sat = 1'b0;
      prev_stall = 1'b0;
    end else begin
      occ = q.size();
      chk("in_tready", bus.in_tready, !(occ == 2 && !bus.out_tready));
      if (prev_stall) begin
        chk("hold_valid", bus.out_tvalid, 1);
        chk("hold_data", bus.out_tdata, prev_data);
        chk("hold_last", bus.out_tlast, prev_last);
      end
      if (bus.out_tvalid && bus.out_tready) begin
        chk("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e_pop = q.pop_front();
          chk("out_data", bus.out_tdata, e_pop.data);
          chk("out_last", bus.out_tlast, e_pop.last);
          if (e_pop.sat) chk("sat_flag_set", bus.sat_flag, 1);
          if (lat_chk) chk("latency", cyc - e_pop.cyc, 2);
          last_i = int'($signed(bus.out_tdata[2*W-1:W]));
          last_q = int'($signed(bus.out_tdata[W-1:0]));
          out_i_log.push_back(last_i);
          n_out++;
        end
      end
      if (bus.in_tvalid && bus.in_tready) begin
        use_s = (!bus.scale_latch || first) ? bus.scale_tdata : held;
        held  = use_s;
        first = bus.in_tlast;
        model_beat(bus.in_tdata, use_s, e_new.data, e_new.sat);
        e_new.last = bus.in_tlast;
        e_new.cyc  = cyc;
        any_sat |= e_new.sat;
        q.push_back(e_new);
      end
      prev_stall = bus.out_tvalid && !bus.out_tready;
      prev_data  = bus.out_tdata;
      prev_last  = bus.out_tlast;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [N*2*W-1:0] all_ch(input int i, input int qv);
    logic [N*2*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*2*W +: 2*W] = {W'(i), W'(qv)};
    return v;
  endfunction

  function automatic logic [N*W-1:0] all_sc(input int s);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(s);
    return v;
  endfunction

  // Call at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic send(input logic [N*2*W-1:0] d, input logic [N*W-1:0] s,
                      input logic last);
    int t;
    bus.in_tvalid   = 1'b1;
    bus.in_tdata    = d;
    bus.scale_tdata = s;
    bus.in_tlast    = last;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_tready && t < 500);
    chk("send_accept", bus.in_tready, 1);
    @(posedge clk);
    #1;
    bus.in_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("out_count", n_out, target);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [N*2*W-1:0] d;
  logic [N*W-1:0]   s;
  logic             lst;
  bit               pkt_start;
  int               base;

  initial begin
    bus.in_tvalid = 1'b0; bus.in_tlast = 1'b0; bus.in_tdata = '0;
    bus.scale_tdata = '0; bus.scale_latch = 1'b0; bus.sat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_tvalid", bus.out_tvalid, 0);
    chk("rst_out_tlast", bus.out_tlast, 0);
    chk("rst_out_tdata", bus.out_tdata, 0);
    chk("rst_sat_flag", bus.sat_flag, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_tready", bus.in_tready, 1);

    // Unity weights: 4 x 100 and 4 x -50, two-cycle latency.
    lat_chk = 1'b1;
    send(all_ch(100, -50), all_sc(1024), 1'b1);
    wait_out(1);
    lat_chk = 1'b0;
    chk("unity_i", last_i, 400);
    chk("unity_q", last_q, -200);
    chk("unity_sat", bus.sat_flag, 0);

    // Product saturation on ch0.
    d = '0; d[W +: W] = 16'sd32767;
    s = '0; s[0 +: W] = 16'sd32767;
    send(d, s, 1'b1);
    wait_out(2);
    chk("psat_i", last_i, 32767);
    chk("psat_q", last_q, 0);
    chk("psat_flag", bus.sat_flag, 1);
    // Sum saturation: 4 x -32768.
    send(all_ch(-32768, 0), all_sc(1024), 1'b1);
    wait_out(3);
    chk("ssat_i", last_i, -32768);
    chk("ssat_flag", bus.sat_flag, 1);
    bus.sat_clear = 1'b1;
    any_sat = 1'b0;
    @(posedge clk); #1;
    bus.sat_clear = 1'b0;
    chk("clr_flag", bus.sat_flag, 0);

    // Floor truncation, no saturation.
    d = '0; d[W +: W] = 16'sd1023; d[0 +: W] = -16'sd1;
    s = '0; s[0 +: W] = 16'sd1;
    send(d, s, 1'b1);
    wait_out(4);
    chk("floor_i", last_i, 0);
    chk("floor_q", last_q, -1);
    chk("floor_flag", bus.sat_flag, 0);

    // Scale latching: beats 2-4 present new scales, packet keeps 1024.
    bus.scale_latch = 1'b1;
    send(all_ch(100, 0), all_sc(1024), 1'b0);
    send(all_ch(100, 0), all_sc(2048), 1'b0);
    send(all_ch(100, 0), all_sc(2048), 1'b0);
    send(all_ch(100, 0), all_sc(2048), 1'b1);
    send(all_ch(100, 0), all_sc(2048), 1'b1);
    wait_out(9);
    for (int k = 4; k < 8; k++) chk("latch_held", out_i_log[k], 400);
    chk("latch_next_pkt", out_i_log[8], 800);
    bus.scale_latch = 1'b0;

    // Random stream with random backpressure.
    rdy_mode = 1;
    pkt_start = 1'b1;
    for (int b = 0; b < 200; b++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      if (pkt_start) bus.scale_latch = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) begin
        d[k*2*W +: 2*W] = (2*W)'($urandom);
        if ($urandom_range(0, 3) == 0) s[k*W +: W] = W'($urandom);
        else s[k*W +: W] = W'(int'($urandom_range(0, 4096)) - 2048);
      end
      lst = (b == 199) || ($urandom_range(0, 4) == 0);
      pkt_start = lst;
      send(d, s, lst);
    end
    rdy_mode = 0;
    wait_out(209);
    chk("rand_sat_flag", bus.sat_flag, any_sat);
    bus.scale_latch = 1'b0;

    // Asynchronous reset while output is stalled and valid.
    rdy_mode = 2;
    @(posedge clk); #1;
    d = '0; d[W +: W] = 16'sd32767;
    s = '0; s[0 +: W] = 16'sd32767;
    send(d, s, 1'b1);
    send(all_ch(7, 7), all_sc(1024), 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_valid", bus.out_tvalid, 1);
    chk("pre_rst_flag", bus.sat_flag, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_tvalid, 0);
    chk("async_rst_flag", bus.sat_flag, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    base = n_out;
    send(all_ch(100, -50), all_sc(1024), 1'b1);
    wait_out(base + 1);
    chk("post_rst_i", last_i, 400);
    chk("post_rst_q", last_q, -200);
    chk("post_rst_count", n_out, base + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
